// File: rtl/decomp_arb.sv
`default_nettype none
// ============================================================================
// Module   : decomp_arb
// Brief    : Round-robin arbiter sharing one pipelined decomp unit among
//            NUM_REQ requesters, with a credit-protected in-order result FIFO.
// Revision : 1.0
// ============================================================================
module decomp_arb #(
    parameter int NUM_REQ     = 4,
    parameter int LUT_WIDTH   = 4,
    parameter int TRUNC_WIDTH = 16,
    parameter int DATA_WIDTH  = 18,
    parameter int LAT         = 1,
    parameter int DEPTH       = 4
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic [NUM_REQ-1:0]                                req_valid,
    input  logic [NUM_REQ*(LUT_WIDTH+TRUNC_WIDTH)-1:0]        req_data,
    output logic [NUM_REQ-1:0]                                req_ready,
    output logic [LUT_WIDTH+TRUNC_WIDTH-1:0]                  dec_in,
    input  logic [DATA_WIDTH-1:0]                             dec_lut_out,
    input  logic [TRUNC_WIDTH-1:0]                            dec_trunc_out,
    output logic                                              res_valid,
    input  logic                                              res_ready,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0]  res_id,
    output logic [DATA_WIDTH-1:0]                             res_lut,
    output logic [TRUNC_WIDTH-1:0]                            res_trunc,
    output logic                                              busy
);

    localparam int c_id_w  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_in_w  = LUT_WIDTH + TRUNC_WIDTH;
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic [c_id_w-1:0]      r_ptr;
    logic [LAT-1:0]         r_pv;
    logic [c_id_w-1:0]      r_pid [LAT];
    logic [c_id_w-1:0]      r_mem_id  [DEPTH];
    logic [DATA_WIDTH-1:0]  r_mem_lut [DEPTH];
    logic [TRUNC_WIDTH-1:0] r_mem_tr  [DEPTH];
    logic [c_ptr_w-1:0]     r_wr;
    logic [c_ptr_w-1:0]     r_rd;
    logic [c_cnt_w-1:0]     r_cnt;

    logic              w_found;
    logic [c_id_w-1:0] w_gid;
    int                w_idx;
    int                w_inflight;
    logic              w_pop;
    logic              w_push;
    logic              w_credit;
    logic              w_issue;

    // Round-robin search starting at r_ptr.
    always_comb begin
        w_found = 1'b0;
        w_gid   = '0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (32'(r_ptr) + k) % NUM_REQ;
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gid   = c_id_w'(w_idx);
            end
        end
    end

    always_comb begin
        w_inflight = 0;
        for (int k = 0; k < LAT; k++) begin
            w_inflight = w_inflight + 32'(r_pv[k]);
        end
    end

    assign w_pop    = (r_cnt != '0) && res_ready;
    assign w_push   = r_pv[LAT-1];
    // A pop this cycle frees a slot, so back-to-back throughput survives a full FIFO.
    assign w_credit = (32'(r_cnt) + w_inflight - (w_pop ? 1 : 0)) < DEPTH;
    assign w_issue  = w_found && w_credit && !reset;

    assign req_ready = w_issue ? (NUM_REQ'(1) << w_gid) : '0;
    assign dec_in    = w_issue ? req_data[32'(w_gid)*c_in_w +: c_in_w] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
            r_pv  <= '0;
            for (int k = 0; k < LAT; k++) begin
                r_pid[k] <= '0;
            end
        end else begin
            if (w_issue) begin
                r_ptr <= c_id_w'((32'(w_gid) + 1) % NUM_REQ);
            end
            for (int k = LAT - 1; k > 0; k--) begin
                r_pv[k]  <= r_pv[k-1];
                r_pid[k] <= r_pid[k-1];
            end
            r_pv[0]  <= w_issue;
            r_pid[0] <= w_gid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + c_ptr_w'(1);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - c_cnt_w'(1);
            end
        end
    end

    // Storage needs no reset; outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_id[r_wr]  <= r_pid[LAT-1];
            r_mem_lut[r_wr] <= dec_lut_out;
            r_mem_tr[r_wr]  <= dec_trunc_out;
        end
    end

    assign res_valid = (r_cnt != '0);
    assign res_id    = res_valid ? r_mem_id[r_rd]  : '0;
    assign res_lut   = res_valid ? r_mem_lut[r_rd] : '0;
    assign res_trunc = res_valid ? r_mem_tr[r_rd]  : '0;
    assign busy      = (w_inflight != 0) || (r_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_decomp_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_decomp_arb
// Brief    : Directed scoreboard bench for decomp_arb with a behavioural
//            single-stage decomp unit model.
// Revision : 1.0
// ============================================================================
module tb_decomp_arb;

    localparam int NUM_REQ = 4;
    localparam int LW      = 4;
    localparam int TW      = 16;
    localparam int DW      = 18;
    localparam int LAT     = 1;
    localparam int DEPTH   = 4;
    localparam int IW      = LW + TW;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*IW-1:0]   req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic [IW-1:0]           dec_in;
    logic [DW-1:0]           dec_lut_out;
    logic [TW-1:0]           dec_trunc_out;
    logic                    res_valid;
    logic                    res_ready;
    logic [1:0]              res_id;
    logic [DW-1:0]           res_lut;
    logic [TW-1:0]           res_trunc;
    logic                    busy;

    decomp_arb #(
        .NUM_REQ(NUM_REQ), .LUT_WIDTH(LW), .TRUNC_WIDTH(TW),
        .DATA_WIDTH(DW), .LAT(LAT), .DEPTH(DEPTH)
    ) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .dec_in(dec_in), .dec_lut_out(dec_lut_out), .dec_trunc_out(dec_trunc_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_lut(res_lut), .res_trunc(res_trunc), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] lutf(input logic [LW-1:0] a);
        return 18'h2_0000 | (18'(a) * 18'h00111);
    endfunction

    // Single-stage decomp unit: registers dec_in, outputs valid one cycle later.
    logic [IW-1:0] r_dq;
    always @(posedge clk) r_dq <= dec_in;
    assign dec_lut_out   = lutf(r_dq[IW-1:TW]);
    assign dec_trunc_out = r_dq[TW-1:0];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]    id;
        logic [DW-1:0] lut;
        logic [TW-1:0] tr;
        int            gcyc;
        bit            chklat;
    } res_t;

    res_t rq[$];
    int   gq[$];
    bit   chk_lat_mode = 1'b0;
    bit   auto_data    = 1'b1;
    int   seed         = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Grant monitor: compares the winner and pushes the expected result.
    always @(negedge clk) begin
        if (!reset && req_ready != '0) begin
            int            g;
            int            e;
            logic [IW-1:0] op;
            res_t          r;
            g = 0;
            for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) g = i;
            chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
            if (gq.size() == 0) begin
                chk("unexpected_grant", 32'(req_ready), 32'd0);
            end else begin
                e  = gq.pop_front();
                chk("grant", 32'(g), 32'(e));
                op = req_data[e*IW +: IW];
                chk("dec_in", 32'(dec_in), 32'(op));
                r.id     = 2'(e);
                r.lut    = lutf(op[IW-1:TW]);
                r.tr     = op[TW-1:0];
                r.gcyc   = cyc;
                r.chklat = chk_lat_mode;
                rq.push_back(r);
            end
        end
    end

    // Result monitor: in-order pop check plus hold-stability check.
    bit            hold_v = 1'b0;
    logic [1:0]    h_id;
    logic [DW-1:0] h_lut;
    logic [TW-1:0] h_tr;
    always @(negedge clk) begin
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && res_valid) begin
                chk("hold_id", 32'(res_id), 32'(h_id));
                chk("hold_lut", 32'(res_lut), 32'(h_lut));
                chk("hold_trunc", 32'(res_trunc), 32'(h_tr));
            end
            hold_v = res_valid && !res_ready;
            h_id   = res_id;
            h_lut  = res_lut;
            h_tr   = res_trunc;
            if (res_valid && res_ready) begin
                if (rq.size() == 0) begin
                    chk("unexpected_result", {14'h0, res_lut}, 32'h0);
                end else begin
                    res_t r;
                    r = rq.pop_front();
                    chk("res_id", 32'(res_id), 32'(r.id));
                    chk("res_lut", 32'(res_lut), 32'(r.lut));
                    chk("res_trunc", 32'(res_trunc), 32'(r.tr));
                    if (r.chklat) chk("latency", 32'(cyc - r.gcyc), 32'(LAT + 1));
                end
            end
        end
    end

    task automatic new_data();
        if (auto_data) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_data[i*IW +: IW] = {4'(seed + i * 3), 16'(seed * 16'h1357 + i * 16'h0101)};
            end
            seed++;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            new_data();
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || rq.size() != 0) && n < 60) begin
            step(1);
            n++;
        end
        chk("drain_busy", 32'(busy), 32'd0);
        chk("leftover_grants", 32'(gq.size()), 32'd0);
        chk("leftover_results", 32'(rq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        req_valid = '1;
        new_data();
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_dec_in", 32'(dec_in), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_res_lut", 32'(res_lut), 32'd0);
        chk("rst_res_trunc", 32'(res_trunc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        req_valid = '0;

        // Round-robin order 0,1,2,3,0 straight out of reset, LAT+1 latency.
        @(posedge clk);
        #1;
        chk_lat_mode = 1'b1;
        gq.push_back(0); gq.push_back(1); gq.push_back(2); gq.push_back(3); gq.push_back(0);
        reset     = 1'b0;
        req_valid = '1;
        step(5);
        req_valid = '0;
        wait_idle();

        // Single requester 2 with operand 0x5_1234.
        auto_data = 1'b0;
        req_data  = '0;
        req_data[2*IW +: IW] = 20'h51234;
        gq.push_back(2);
        req_valid = 4'b0100;
        #2;
        chk("t3_req_ready", 32'(req_ready), 32'h4);
        chk("t3_dec_in", 32'(dec_in), 32'h51234);
        step(1);
        req_valid = '0;
        begin
            int n;
            n = 0;
            while (!res_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
        end
        #1;
        chk("t3_res_valid", 32'(res_valid), 32'd1);
        chk("t3_res_id", 32'(res_id), 32'd2);
        chk("t3_res_trunc", 32'(res_trunc), 32'h1234);
        chk("t3_res_lut", 32'(res_lut), 32'h20555);
        wait_idle();

        // Backpressure: exactly DEPTH issues, then stall with stable output.
        auto_data    = 1'b1;
        chk_lat_mode = 1'b0;
        res_ready    = 1'b0;
        gq.push_back(3); gq.push_back(0); gq.push_back(1); gq.push_back(2);
        req_valid = '1;
        step(8);
        chk("t4_stall_ready", 32'(req_ready), 32'd0);
        chk("t4_res_valid", 32'(res_valid), 32'd1);
        chk("t4_busy", 32'(busy), 32'd1);
        chk("t4_head_id", 32'(res_id), 32'd3);
        step(2);
        chk("t4_still_stalled", 32'(req_ready), 32'd0);
        chk("t4_head_id_stable", 32'(res_id), 32'd3);
        // Full FIFO drains while refilling: one issue per popped entry.
        gq.push_back(3); gq.push_back(0); gq.push_back(1); gq.push_back(2);
        res_ready = 1'b1;
        step(4);
        req_valid = '0;
        wait_idle();

        // Move ptr to 2, then requesters 1 and 3: 3 first, then 1.
        gq.push_back(1);
        req_valid = 4'b0010;
        step(1);
        gq.push_back(3); gq.push_back(1);
        req_valid = 4'b1010;
        step(2);
        req_valid = '0;
        wait_idle();

        // Reset mid-stream: one result queued, one in flight.
        res_ready = 1'b0;
        gq.push_back(2); gq.push_back(3);
        req_valid = '1;
        step(2);
        req_valid = '0;
        chk("t6_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        gq.delete();
        rq.delete();
        #1;
        chk("t6_res_valid", 32'(res_valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_req_ready", 32'(req_ready), 32'd0);
        step(2);
        reset     = 1'b0;
        res_ready = 1'b1;
        gq.push_back(0);
        req_valid = '1;
        step(1);
        req_valid = '0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
